// File: rtl/led_mode_ctrl_pkg.sv
// Shared definitions for the LED mode controller: mode encoding, entry patterns
// and the small helpers that map a mode to its pattern and successor.
package led_mode_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_RUN    = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    localparam logic [3:0] PAT_NONE  = 4'b0000;
    localparam logic [3:0] PAT_ALL   = 4'b1111;
    localparam logic [3:0] PAT_FIRST = 4'b0001;
    localparam logic [3:0] PAT_LAST  = 4'b1000;

    // Pattern loaded whenever a mode is (re)entered.
    function automatic logic [3:0] entry_pattern(input mode_e m);
        logic [3:0] pat;
        case (m)
            MODE_BLINK:  pat = PAT_ALL;
            MODE_RUN:    pat = PAT_FIRST;
            MODE_BOUNCE: pat = PAT_FIRST;
            default:     pat = PAT_NONE;
        endcase
        return pat;
    endfunction

    // Pushbutton order: OFF -> BLINK -> RUN -> BOUNCE -> OFF.
    function automatic mode_e next_mode(input mode_e m);
        logic [1:0] nxt;
        nxt = m + 2'd1;
        return mode_e'(nxt);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton front end: two-flop synchronizer, stability counter and a
// one-cycle press pulse on each accepted press (release is silent).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             stable;
    logic [CNT_W-1:0] count;

    // NOTE: synchronizer and stable level reset to the released (high) level so
    // leaving reset with the key idle never looks like a press.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            stable <= 1'b1;
            count  <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 == stable) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                stable <= sync_2;
                count  <= '0;
                // Only a 1 -> 0 change of the accepted level is a press.
                press  <= stable;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_mode_ctrl.sv
// Sequences four user LEDs through OFF / BLINK / RUN / BOUNCE, stepping on a
// shared prescaler tick; mode comes from the config port or the pushbutton.
module led_mode_ctrl #(
    parameter int TICK_CYCLES     = 12_500_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       key_n,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [1:0] cfg_mode,
    input  logic [1:0] cfg_speed,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       tick
);

    import led_mode_ctrl_pkg::*;

    localparam logic [31:0] TICK_LEN = 32'(TICK_CYCLES);

    mode_e       mode_r;
    mode_e       cfg_mode_e;
    mode_e       press_mode;
    logic [1:0]  speed_r;
    logic        dir_up;
    logic [31:0] cnt;
    logic [31:0] tick_limit;
    logic        press;
    logic        xfer;
    logic        tick_due;
    logic [3:0]  step_led;
    logic        step_dir_up;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .sys_clk(sys_clk),
        .rst    (rst),
        .key_n  (key_n),
        .press  (press)
    );

    assign mode = mode_r;

    always_comb begin
        xfer       = cfg_valid && cfg_ready;
        cfg_mode_e = mode_e'(cfg_mode);
        press_mode = next_mode(mode_r);
        // Compared with >= so a shorter period never has to wrap the counter.
        tick_limit = (TICK_LEN >> speed_r) - 32'd1;
        tick_due   = (cnt >= tick_limit);
    end

    // Next pattern for the current mode when a tick lands.
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        step_led    = PAT_NONE;
        step_dir_up = dir_up;
        case (mode_r)
            MODE_BLINK: step_led = ~led;
            MODE_RUN:   step_led = {led[2:0], led[3]};
            MODE_BOUNCE: begin
                if (dir_up) begin
                    step_led = {led[2:0], 1'b0};
                    if (step_led == PAT_LAST) step_dir_up = 1'b0;
                end else begin
                    step_led = {1'b0, led[3:1]};
                    if (step_led == PAT_FIRST) step_dir_up = 1'b1;
                end
            end
            default: step_led = PAT_NONE;
        endcase
    end

    // Config transfer has priority over a press in the same cycle; either one
    // restarts the pattern and the prescaler.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            mode_r    <= MODE_OFF;
            speed_r   <= 2'd0;
            dir_up    <= 1'b1;
            cnt       <= 32'd0;
            tick      <= 1'b0;
            led       <= PAT_NONE;
            cfg_ready <= 1'b0;
        end else if (xfer) begin
            mode_r    <= cfg_mode_e;
            speed_r   <= cfg_speed;
            dir_up    <= 1'b1;
            cnt       <= 32'd0;
            tick      <= 1'b0;
            led       <= entry_pattern(cfg_mode_e);
            cfg_ready <= 1'b0;
        end else begin
            cfg_ready <= 1'b1;
            if (press) begin
                mode_r <= press_mode;
                dir_up <= 1'b1;
                cnt    <= 32'd0;
                tick   <= 1'b0;
                led    <= entry_pattern(press_mode);
            end else if (tick_due) begin
                cnt    <= 32'd0;
                tick   <= 1'b1;
                led    <= step_led;
                dir_up <= step_dir_up;
            end else begin
                cnt    <= cnt + 32'd1;
                tick   <= 1'b0;
            end
        end
    end

endmodule
